// File: rtl/ibex_pkg.sv
// Shared types for the static branch prediction path: the prediction record
// carried from fetch to resolution and the resolution FSM states.
package ibex_pkg;

    typedef struct packed {
        logic [31:0] instr_pc;
        logic [31:0] target;
        logic        taken;
        logic        compressed;
    } bp_rec_t;

    typedef enum logic {
        BR_RUN      = 1'b0,
        BR_REDIRECT = 1'b1
    } br_state_t;

    localparam logic [31:0] INSTR_LEN_16 = 32'd2;
    localparam logic [31:0] INSTR_LEN_32 = 32'd4;

    // Fall-through PC of a predicted instruction; wraps at 32 bits.
    function automatic logic [31:0] bp_seq_pc(input bp_rec_t rec);
        return rec.instr_pc + (rec.compressed ? INSTR_LEN_16 : INSTR_LEN_32);
    endfunction

endpackage

// File: rtl/ibex_branch_pred_queue.sv
// In-order queue of outstanding prediction records; push/pop take effect at the
// clock edge, head is combinational, clear beats push/pop, full/empty gate the caller.
module ibex_branch_pred_queue
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  bp_rec_t push_rec,
    input  logic    pop,
    input  logic    clear,
    output bp_rec_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    bp_rec_t     mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= push_rec;
        end
    end

endmodule

// File: rtl/ibex_branch_resolve.sv
// Matches fetch-time predictions against EX outcomes in program order, raises a
// registered one-cycle redirect on mispredict and keeps saturating statistics.
module ibex_branch_resolve
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pred_valid_i,
    output logic             pred_ready_o,
    input  logic [31:0]      pred_instr_pc_i,
    input  logic [31:0]      pred_target_i,
    input  logic             pred_taken_i,
    input  logic             pred_compressed_i,
    input  logic             res_valid_i,
    output logic             res_ready_o,
    input  logic             res_taken_i,
    input  logic [31:0]      res_target_i,
    input  logic             flush_i,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    br_state_t        state_q;
    br_state_t        state_d;
    bp_rec_t          push_rec;
    bp_rec_t          head;
    logic             q_full;
    logic             q_empty;
    logic             q_push;
    logic             q_pop;
    logic             q_clear;
    logic             pred_hs;
    logic             res_hs;
    logic             mispredict;
    logic [31:0]      correct_pc;
    logic             redirect_q;
    logic             redirect_d;
    logic [31:0]      redirect_pc_q;
    logic [31:0]      redirect_pc_d;
    logic             cnt_en;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;

    assign push_rec = '{
        instr_pc:   pred_instr_pc_i,
        target:     pred_target_i,
        taken:      pred_taken_i,
        compressed: pred_compressed_i
    };

    assign pred_ready_o = !q_full && (state_q == BR_RUN);
    assign res_ready_o  = !q_empty && (state_q == BR_RUN);
    assign pred_hs      = pred_valid_i && pred_ready_o;
    assign res_hs       = res_valid_i && res_ready_o;

    assign mispredict = (head.taken != res_taken_i) ||
                        (res_taken_i && (head.target != res_target_i));
    assign correct_pc = res_taken_i ? res_target_i : bp_seq_pc(head);

    assign cnt_en = res_hs && !flush_i;

    ibex_branch_pred_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (q_push),
        .push_rec (push_rec),
        .pop      (q_pop),
        .clear    (q_clear),
        .head     (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= BR_RUN;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        q_push        = pred_hs;
        q_pop         = res_hs;
        q_clear       = 1'b0;

        if (flush_i) begin
            q_push  = 1'b0;
            q_pop   = 1'b0;
            q_clear = 1'b1;
            state_d = BR_RUN;
        end else begin
            unique case (state_q)
                BR_RUN: begin
                    // Everything behind a mispredicted head is wrong-path, including a same-cycle push.
                    if (res_hs && mispredict) begin
                        q_push        = 1'b0;
                        q_pop         = 1'b0;
                        q_clear       = 1'b1;
                        redirect_d    = 1'b1;
                        redirect_pc_d = correct_pc;
                        state_d       = BR_REDIRECT;
                    end
                end
                BR_REDIRECT: begin
                    state_d = BR_RUN;
                end
                default: begin
                    state_d = BR_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (cnt_en) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mispredict && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
        end
    end

    assign redirect_o       = redirect_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign empty_o          = q_empty;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

    res_never_on_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        (res_valid_i && res_ready_o) |-> !q_empty);

    redirect_single_cycle: assert property (@(posedge clk_i) disable iff (rst_i)
        redirect_o |=> !redirect_o);

endmodule

// File: tb/tb_ibex_branch_resolve.sv
module tb_ibex_branch_resolve;
    import ibex_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             pred_valid_i;
    logic             pred_ready_o;
    logic [31:0]      pred_instr_pc_i;
    logic [31:0]      pred_target_i;
    logic             pred_taken_i;
    logic             pred_compressed_i;
    logic             res_valid_i;
    logic             res_ready_o;
    logic             res_taken_i;
    logic [31:0]      res_target_i;
    logic             flush_i;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic             empty_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    always #5 clk = ~clk;

    ibex_branch_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .pred_valid_i      (pred_valid_i),
        .pred_ready_o      (pred_ready_o),
        .pred_instr_pc_i   (pred_instr_pc_i),
        .pred_target_i     (pred_target_i),
        .pred_taken_i      (pred_taken_i),
        .pred_compressed_i (pred_compressed_i),
        .res_valid_i       (res_valid_i),
        .res_ready_o       (res_ready_o),
        .res_taken_i       (res_taken_i),
        .res_target_i      (res_target_i),
        .flush_i           (flush_i),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .empty_o           (empty_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispredict_cnt_o  (mispredict_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: outstanding records, expected redirect PCs, counters.
    bp_rec_t     mq[$];
    logic [31:0] exp_q[$];
    logic        m_redir;
    logic [31:0] m_pc;
    int          m_b;
    int          m_m;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        t;
        logic        c;
        logic        rt;
        logic [31:0] rtgt;
        logic        mis;
        logic [31:0] epc;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic bp_rec_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                                   input logic t, input logic c);
        bp_rec_t r;
        r.instr_pc   = pc;
        r.target     = tgt;
        r.taken      = t;
        r.compressed = c;
        return r;
    endfunction

    task automatic cycle(input logic pv, input bp_rec_t pr, input logic rv,
                         input logic rt, input logic [31:0] rtg, input logic fl);
        bp_rec_t     h;
        logic        m_pr, m_rr, phs, rhs, mis;
        logic [31:0] cpc;
        pred_valid_i      = pv;
        pred_instr_pc_i   = pr.instr_pc;
        pred_target_i     = pr.target;
        pred_taken_i      = pr.taken;
        pred_compressed_i = pr.compressed;
        res_valid_i       = rv;
        res_taken_i       = rt;
        res_target_i      = rtg;
        flush_i           = fl;
        m_pr = (mq.size() < DEPTH) && !m_redir;
        m_rr = (mq.size() != 0) && !m_redir;
        check("pred_ready", 32'(pred_ready_o), 32'(m_pr));
        check("res_ready", 32'(res_ready_o), 32'(m_rr));
        phs = pv && m_pr;
        rhs = rv && m_rr;
        if (fl) begin
            mq.delete();
            m_redir = 1'b0;
        end else if (m_redir) begin
            m_redir = 1'b0;
        end else if (rhs) begin
            h   = mq[0];
            mis = (h.taken != rt) || (rt && (h.target != rtg));
            cpc = rt ? rtg : h.instr_pc + (h.compressed ? 32'd2 : 32'd4);
            if (m_b < CMAX) m_b++;
            if (mis && (m_m < CMAX)) m_m++;
            if (mis) begin
                mq.delete();
                exp_q.push_back(cpc);
                m_redir = 1'b1;
            end else begin
                void'(mq.pop_front());
                if (phs) mq.push_back(pr);
            end
        end else if (phs) begin
            mq.push_back(pr);
        end
        @(posedge clk);
        #1;
        pred_valid_i = 1'b0;
        res_valid_i  = 1'b0;
        flush_i      = 1'b0;
        if (exp_q.size() != 0) begin
            m_pc = exp_q.pop_front();
            check("redirect", 32'(redirect_o), 32'd1);
        end else begin
            check("redirect", 32'(redirect_o), 32'd0);
        end
        check("redirect_pc", redirect_pc_o, m_pc);
        check("branch_cnt", 32'(branch_cnt_o), 32'(m_b));
        check("mispredict_cnt", 32'(mispredict_cnt_o), 32'(m_m));
        check("empty", 32'(empty_o), 32'(mq.size() == 0));
    endtask

    task automatic push_rec(input bp_rec_t r);
        cycle(1'b1, r, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] rtg);
        cycle(1'b0, mk(32'h0, 32'h0, 1'b0, 1'b0), 1'b1, rt, rtg, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, mk(32'h0, 32'h0, 1'b0, 1'b0), 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_redir = 1'b0;
        m_pc    = 32'h0;
        m_b     = 0;
        m_m     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_redirect"}, 32'(redirect_o), 32'd0);
        check({tag, "_redirect_pc"}, redirect_pc_o, 32'h0);
        check({tag, "_branch_cnt"}, 32'(branch_cnt_o), 32'd0);
        check({tag, "_mispredict_cnt"}, 32'(mispredict_cnt_o), 32'd0);
        check({tag, "_empty"}, 32'(empty_o), 32'd1);
        check({tag, "_res_ready"}, 32'(res_ready_o), 32'd0);
    endtask

    initial begin
        int b0, m0;
        tbl[0] = '{32'h0000_0100, 32'h0000_00F0, 1'b1, 1'b0, 1'b1, 32'h0000_00F0, 1'b0, 32'h0};
        tbl[1] = '{32'h0000_0200, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0240, 1'b1, 32'h0000_0240};
        tbl[2] = '{32'h0000_0400, 32'h0000_0480, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0404};
        tbl[3] = '{32'h0000_0500, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
        tbl[4] = '{32'h0000_0600, 32'h0000_0700, 1'b1, 1'b0, 1'b1, 32'h0000_0710, 1'b1, 32'h0000_0710};
        tbl[5] = '{32'hFFFF_FFFE, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tbl[6] = '{32'h0000_0800, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0};

        rst_i = 1'b1;
        pred_valid_i = 1'b0; pred_instr_pc_i = '0; pred_target_i = '0;
        pred_taken_i = 1'b0; pred_compressed_i = 1'b0;
        res_valid_i = 1'b0; res_taken_i = 1'b0; res_target_i = '0; flush_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_reset_outputs("reset");
        check("reset_pred_ready", 32'(pred_ready_o), 32'd1);

        // Single push/resolve pairs with hand-computed outcomes.
        for (int i = 0; i < 7; i++) begin
            push_rec(mk(tbl[i].pc, tbl[i].tgt, tbl[i].t, tbl[i].c));
            resolve(tbl[i].rt, tbl[i].rtgt);
            check($sformatf("tbl%0d_redirect", i), 32'(redirect_o), 32'(tbl[i].mis));
            if (tbl[i].mis) begin
                check($sformatf("tbl%0d_pc", i), redirect_pc_o, tbl[i].epc);
                check($sformatf("tbl%0d_pred_ready_redir", i), 32'(pred_ready_o), 32'd0);
                idle();
                check($sformatf("tbl%0d_redirect_drop", i), 32'(redirect_o), 32'd0);
            end
            if (i == 0) begin
                check("tbl0_branch_cnt", 32'(branch_cnt_o), 32'd1);
                check("tbl0_mispredict_cnt", 32'(mispredict_cnt_o), 32'd0);
                check("tbl0_empty", 32'(empty_o), 32'd1);
            end
        end

        // Mispredicted head with younger wrong-path records and a same-cycle push.
        push_rec(mk(32'h300, 32'h2F0, 1'b1, 1'b0));
        push_rec(mk(32'h310, 32'h0, 1'b0, 1'b0));
        push_rec(mk(32'h320, 32'h0, 1'b0, 1'b1));
        cycle(1'b1, mk(32'h330, 32'h0, 1'b0, 1'b0), 1'b1, 1'b0, 32'h0, 1'b0);
        check("wp_redirect_pc", redirect_pc_o, 32'h304);
        check("wp_pred_ready_redir", 32'(pred_ready_o), 32'd0);
        check("wp_empty", 32'(empty_o), 32'd1);
        cycle(1'b1, mk(32'h340, 32'h0, 1'b0, 1'b0), 1'b0, 1'b0, 32'h0, 1'b0);
        check("wp_empty_after", 32'(empty_o), 32'd1);

        // Fill, push refused at full, pop+push at 3, refill, drain across pointer wrap.
        b0 = m_b;
        for (int i = 0; i < DEPTH; i++) push_rec(mk(32'h1000 + 32'(i * 16), 32'h0, 1'b0, 1'b0));
        check("full_pred_ready", 32'(pred_ready_o), 32'd0);
        cycle(1'b1, mk(32'h1040, 32'h0, 1'b0, 1'b0), 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, mk(32'h1050, 32'h0, 1'b0, 1'b0), 1'b1, 1'b0, 32'h0, 1'b0);
        check("popush_pred_ready", 32'(pred_ready_o), 32'd1);
        push_rec(mk(32'h1060, 32'h0, 1'b0, 1'b1));
        check("refull_pred_ready", 32'(pred_ready_o), 32'd0);
        for (int i = 0; i < DEPTH; i++) resolve(1'b0, 32'h0);
        check("drain_empty", 32'(empty_o), 32'd1);
        check("drain_branch_cnt", 32'(branch_cnt_o), 32'((b0 + 6 > CMAX) ? CMAX : b0 + 6));

        // Flush during the redirect cycle, then flush cancelling a mispredict.
        push_rec(mk(32'h900, 32'h0, 1'b0, 1'b0));
        resolve(1'b1, 32'h950);
        check("fl_redirect_pc", redirect_pc_o, 32'h950);
        cycle(1'b0, mk(32'h0, 32'h0, 1'b0, 1'b0), 1'b0, 1'b0, 32'h0, 1'b1);
        check("fl_redirect_off", 32'(redirect_o), 32'd0);
        check("fl_run_ready", 32'(pred_ready_o), 32'd1);
        m0 = m_m;
        b0 = m_b;
        push_rec(mk(32'hA00, 32'h0, 1'b0, 1'b0));
        push_rec(mk(32'hA10, 32'h0, 1'b0, 1'b0));
        cycle(1'b1, mk(32'hA20, 32'h0, 1'b0, 1'b0), 1'b1, 1'b1, 32'hA80, 1'b1);
        check("flm_no_redirect", 32'(redirect_o), 32'd0);
        check("flm_mis_cnt", 32'(mispredict_cnt_o), 32'(m0));
        check("flm_branch_cnt", 32'(branch_cnt_o), 32'(b0));
        check("flm_empty", 32'(empty_o), 32'd1);
        idle();

        // Saturation of both counters.
        for (int i = 0; i < 17; i++) begin
            push_rec(mk(32'hB00 + 32'(i * 4), 32'h0, 1'b0, 1'b0));
            resolve(1'b1, 32'hC00);
            idle();
        end
        check("sat_mispredict_cnt", 32'(mispredict_cnt_o), 32'hF);
        check("sat_branch_cnt", 32'(branch_cnt_o), 32'hF);

        // Reset with records outstanding.
        push_rec(mk(32'hD00, 32'h0, 1'b0, 1'b0));
        push_rec(mk(32'hD10, 32'h0, 1'b1, 1'b0));
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        check_reset_outputs("midrst");
        check("midrst_pred_ready", 32'(pred_ready_o), 32'd1);
        push_rec(mk(32'hE00, 32'hE40, 1'b1, 1'b0));
        resolve(1'b1, 32'hE40);
        check("post_rst_branch_cnt", 32'(branch_cnt_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
